// File: rtl/i2s_tdm_axis_rx.sv
// rtl/i2s_tdm_axis_rx.sv - I2S/TDM serial audio receiver with frame-atomic AXI4-Stream output
// Optional I2S_RX_CH_TAG_EN adds m_axis_tuser carrying the slot index of each beat.
module i2s_tdm_axis_rx #(
    parameter int DATA_W     = 24,
    parameter int SLOT_W     = 32,
    parameter int NUM_CH     = 2,
    parameter int TDM_MODE   = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        m_axis_aclk,
    input  logic        m_axis_areset,
    input  logic        bclk,
    input  logic        lrclk,
    input  logic        sdata,
    output logic        m_axis_tvalid,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
`ifdef I2S_RX_CH_TAG_EN
    output logic [3:0]  m_axis_tuser,
`endif
    output logic        overflow,
    output logic        frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = $clog2(SLOT_W) + 1;
`ifdef I2S_RX_CH_TAG_EN
    localparam int EW = DATA_W + 5;
`else
    localparam int EW = DATA_W + 1;
`endif

    typedef enum logic {HUNT, RUN} state_t;

    state_t state_q, state_d;

    logic [2:0]        bclk_sr;
    logic [1:0]        lr_sr;
    logic [1:0]        sd_sr;
    logic              strobe, lr_s, sd_s;
    logic              primed, lr_prev;
    logic [BW-1:0]     bit_cnt;
    logic [4:0]        slot_cnt;
    logic [DATA_W-1:0] sample;
    logic              wr_req, wr_last;
`ifdef I2S_RX_CH_TAG_EN
    logic [3:0]        wr_slot;
`endif
    logic              lr_changed, bound0, bound1, at_wrap, cap_bit, last_cap, in_run;
    logic              short_err, long_err, wr_go;
    logic              full, do_wr, ovf_hit, rollback, overflow_d, frame_err_d;
    logic [PW-1:0]     spec_wr, com_wr, rd_ptr;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [EW-1:0]     wr_entry, rd_entry;

    assign strobe = bclk_sr[1] & ~bclk_sr[2];
    assign lr_s   = lr_sr[1];
    assign sd_s   = sd_sr[1];

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            bclk_sr <= '0;
            lr_sr   <= '0;
            sd_sr   <= '0;
        end else begin
            bclk_sr <= {bclk_sr[1:0], bclk};
            lr_sr   <= {lr_sr[0], lrclk};
            sd_sr   <= {sd_sr[0], sdata};
        end
    end

    // The first strobe after reset only primes lr_prev so a static lrclk level is not mistaken for an edge.
    assign lr_changed = strobe & primed & (lr_s != lr_prev);
    assign bound0     = lr_changed & ((TDM_MODE != 0) ? lr_s : ~lr_s);
    assign bound1     = lr_changed & (TDM_MODE == 0) & lr_s;
    assign at_wrap    = (bit_cnt == BW'(SLOT_W - 1));
    assign cap_bit    = (bit_cnt < BW'(DATA_W));
    assign last_cap   = (bit_cnt == BW'(DATA_W - 1));
    assign in_run     = (state_q == RUN);
    assign short_err  = bound0 & in_run & (slot_cnt != 5'(NUM_CH - 1));
    assign long_err   = strobe & in_run & ~bound0 & ~bound1 & at_wrap & (slot_cnt == 5'(NUM_CH - 1));
    assign wr_go      = strobe & in_run & last_cap & ~short_err;

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            primed   <= 1'b0;
            lr_prev  <= 1'b0;
            bit_cnt  <= '0;
            slot_cnt <= '0;
            sample   <= '0;
            wr_req   <= 1'b0;
            wr_last  <= 1'b0;
`ifdef I2S_RX_CH_TAG_EN
            wr_slot  <= '0;
`endif
        end else begin
            wr_req <= wr_go;
            if (wr_go) begin
                wr_last <= (slot_cnt == 5'(NUM_CH - 1));
`ifdef I2S_RX_CH_TAG_EN
                wr_slot <= slot_cnt[3:0];
`endif
            end
            if (strobe) begin
                primed  <= 1'b1;
                lr_prev <= lr_s;
                if (cap_bit)
                    sample <= {sample[DATA_W-2:0], sd_s};
                // The bit carrying the lrclk change still belongs to the old slot.
                if (bound0) begin
                    bit_cnt  <= '0;
                    slot_cnt <= '0;
                end else if (bound1) begin
                    bit_cnt  <= '0;
                    slot_cnt <= 5'd1;
                end else if (at_wrap) begin
                    bit_cnt  <= '0;
                    slot_cnt <= slot_cnt + 5'd1;
                end else begin
                    bit_cnt  <= bit_cnt + BW'(1);
                end
            end
        end
    end

    assign full    = ((spec_wr - rd_ptr) == PW'(FIFO_DEPTH));
    assign do_wr   = wr_req & ~full;
    assign ovf_hit = wr_req & full;

    always_comb begin
        state_d     = state_q;
        rollback    = 1'b0;
        overflow_d  = 1'b0;
        frame_err_d = 1'b0;
        if (ovf_hit) begin
            state_d    = HUNT;
            rollback   = 1'b1;
            overflow_d = 1'b1;
        end else if (short_err) begin
            state_d     = RUN;
            rollback    = 1'b1;
            frame_err_d = 1'b1;
        end else if (long_err) begin
            state_d     = HUNT;
            rollback    = 1'b1;
            frame_err_d = 1'b1;
        end else if (bound0) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            state_q   <= HUNT;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            overflow  <= overflow_d;
            frame_err <= frame_err_d;
        end
    end

    // Samples land at the speculative pointer; the reader only sees up to com_wr.
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            spec_wr <= '0;
            com_wr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (rollback) begin
                spec_wr <= com_wr;
            end else if (do_wr) begin
                spec_wr <= spec_wr + PW'(1);
                if (wr_last)
                    com_wr <= spec_wr + PW'(1);
            end
            if (m_axis_tvalid && m_axis_tready)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

`ifdef I2S_RX_CH_TAG_EN
    assign wr_entry = {wr_slot, wr_last, sample};
`else
    assign wr_entry = {wr_last, sample};
`endif

    always_ff @(posedge m_axis_aclk) begin
        if (do_wr)
            mem[spec_wr[AW-1:0]] <= wr_entry;
    end

    assign m_axis_tvalid = (com_wr != rd_ptr);
    assign rd_entry      = mem[rd_ptr[AW-1:0]];

    always_comb begin
        m_axis_tdata = '0;
        m_axis_tlast = 1'b0;
`ifdef I2S_RX_CH_TAG_EN
        m_axis_tuser = '0;
`endif
        if (m_axis_tvalid) begin
            m_axis_tdata = 32'(rd_entry[DATA_W-1:0]) << (32 - DATA_W);
            m_axis_tlast = rd_entry[DATA_W];
`ifdef I2S_RX_CH_TAG_EN
            m_axis_tuser = rd_entry[DATA_W+4:DATA_W+1];
`endif
        end
    end

endmodule

// File: tb/tb_i2s_tdm_axis_rx.sv
// tb/tb_i2s_tdm_axis_rx.sv - directed bench for i2s_tdm_axis_rx in I2S (depth 4) and 8-slot TDM builds
`timescale 1ns/1ps
module tb_i2s_tdm_axis_rx;

    localparam int SW = 32;

    logic aclk = 1'b0;
    logic rst = 1'b1;
    logic bclk = 1'b0;
    logic lrclk = 1'b0;
    logic sdata = 1'b0;
    logic tready = 1'b0;

    logic        a_tvalid, a_tlast, a_ovf, a_ferr;
    logic [31:0] a_tdata;
    logic        b_tvalid, b_tlast, b_ovf, b_ferr;
    logic [31:0] b_tdata;
    logic [3:0]  a_tuser, b_tuser;
`ifndef I2S_RX_CH_TAG_EN
    assign a_tuser = '0;
    assign b_tuser = '0;
`endif

    always #5 aclk = ~aclk;

    i2s_tdm_axis_rx #(.DATA_W(24), .SLOT_W(32), .NUM_CH(2), .TDM_MODE(0), .FIFO_DEPTH(4)) dut_i2s (
        .m_axis_aclk(aclk), .m_axis_areset(rst), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .m_axis_tvalid(a_tvalid), .m_axis_tdata(a_tdata), .m_axis_tlast(a_tlast),
        .m_axis_tready(tready),
`ifdef I2S_RX_CH_TAG_EN
        .m_axis_tuser(a_tuser),
`endif
        .overflow(a_ovf), .frame_err(a_ferr));

    i2s_tdm_axis_rx #(.DATA_W(24), .SLOT_W(32), .NUM_CH(8), .TDM_MODE(1), .FIFO_DEPTH(16)) dut_tdm (
        .m_axis_aclk(aclk), .m_axis_areset(rst), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .m_axis_tvalid(b_tvalid), .m_axis_tdata(b_tdata), .m_axis_tlast(b_tlast),
        .m_axis_tready(tready),
`ifdef I2S_RX_CH_TAG_EN
        .m_axis_tuser(b_tuser),
`endif
        .overflow(b_ovf), .frame_err(b_ferr));

    int checks = 0;
    int errors = 0;
    logic [36:0] qa[$];
    logic [36:0] qb[$];
    int a_ovf_cnt = 0, a_ferr_cnt = 0, b_ovf_cnt = 0, b_ferr_cnt = 0;
    int stall_bad = 0, stall_seen = 0;
    logic a_stall = 1'b0, b_stall = 1'b0;
    logic [32:0] a_hold = '0, b_hold = '0;
    bit tog_en = 1'b0;

    // Beat capture, pulse counting and stall-stability monitoring, all cleared while reset is high.
    always @(negedge aclk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            a_ovf_cnt <= 0; a_ferr_cnt <= 0; b_ovf_cnt <= 0; b_ferr_cnt <= 0;
            a_stall <= 1'b0;
            b_stall <= 1'b0;
        end else begin
            if (a_tvalid && tready) qa.push_back({a_tuser, a_tlast, a_tdata});
            if (b_tvalid && tready) qb.push_back({b_tuser, b_tlast, b_tdata});
            if (a_ovf)  a_ovf_cnt  <= a_ovf_cnt + 1;
            if (a_ferr) a_ferr_cnt <= a_ferr_cnt + 1;
            if (b_ovf)  b_ovf_cnt  <= b_ovf_cnt + 1;
            if (b_ferr) b_ferr_cnt <= b_ferr_cnt + 1;
            if (a_stall && !(a_tvalid && {a_tlast, a_tdata} == a_hold)) stall_bad <= stall_bad + 1;
            if (b_stall && !(b_tvalid && {b_tlast, b_tdata} == b_hold)) stall_bad <= stall_bad + 1;
            if (b_stall) stall_seen <= stall_seen + 1;
            a_stall <= a_tvalid && !tready;
            b_stall <= b_tvalid && !tready;
            a_hold  <= {a_tlast, a_tdata};
            b_hold  <= {b_tlast, b_tdata};
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [36:0] beat(input bit use_b, input int k);
        if (use_b) return (k < qb.size()) ? qb[k] : '1;
        return (k < qa.size()) ? qa[k] : '1;
    endfunction

    task automatic wait_beats(input bit use_b, input int n);
        int cyc = 0;
        while ((use_b ? qb.size() : qa.size()) < n && cyc < 20000) begin
            @(posedge aclk);
            cyc++;
        end
        check("wait_beats_in_budget", 64'(cyc < 20000), 64'd1);
    endtask

    task automatic send_bit(input logic lr, input logic d);
        bclk = 1'b0; lrclk = lr; sdata = d;
        #40;
        bclk = 1'b1;
        #40;
    endtask

    // lrclk takes its next-slot level on the last bit, giving the one-bit delay before the MSB.
    task automatic send_slot(input logic lr_body, input logic lr_last, input logic [23:0] w);
        for (int j = 0; j < SW; j++)
            send_bit((j == SW - 1) ? lr_last : lr_body, (j < 24) ? w[23 - j] : 1'b0);
    endtask

    task automatic i2s_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, 1'b1, l);
        send_slot(1'b1, 1'b0, r);
    endtask

    task automatic tdm_frame(input int n, input int base);
        for (int s = 0; s < n; s++)
            send_slot(1'b0, (s == n - 1), 24'(base + s));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge aclk);
        #2 rst = 1'b0;
    endtask

    task automatic check_tdm_frame(input string name, input int first, input int base);
        logic [36:0] b;
        for (int s = 0; s < 8; s++) begin
            b = beat(1'b1, first + s);
            check(name, {31'd0, b[32:0]}, {31'd0, (s == 7), 24'(base + s), 8'h00});
`ifdef I2S_RX_CH_TAG_EN
            check({name, "_tuser"}, 64'(b[36:33]), 64'(s));
`endif
        end
    endtask

    typedef struct {
        logic [23:0] left;
        logic [23:0] right;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } vec_t;

    vec_t vecs[3];

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=expired required=finish");
        $fatal(1);
    end

    initial begin
        logic [36:0] b;
        vecs[0] = '{24'hA5A5A5, 24'h123456, 32'hA5A5A500, 32'h12345600};
        vecs[1] = '{24'hFFFFFF, 24'h000001, 32'hFFFFFF00, 32'h00000100};
        vecs[2] = '{24'h800000, 24'h7FFFFF, 32'h80000000, 32'h7FFFFF00};

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_a_tvalid", 64'(a_tvalid), 0);
        check("rst_a_tdata", 64'(a_tdata), 0);
        check("rst_a_tlast", 64'(a_tlast), 0);
        check("rst_a_flags", 64'({a_ovf, a_ferr}), 0);
        check("rst_b_tvalid", 64'(b_tvalid), 0);
        check("rst_b_tuser", 64'(b_tuser), 0);
        #1 rst = 1'b0;

        // I2S table of stereo frames
        tready = 1'b1;
        send_slot(1'b1, 1'b0, 24'h0);
        foreach (vecs[i]) i2s_frame(vecs[i].left, vecs[i].right);
        wait_beats(1'b0, 6);
        repeat (10) @(posedge aclk);
        foreach (vecs[i]) begin
            b = beat(1'b0, 2 * i);
            check("i2s_left", 64'(b[32:0]), {31'd0, 1'b0, vecs[i].exp_l});
            b = beat(1'b0, 2 * i + 1);
            check("i2s_right", 64'(b[32:0]), {31'd0, 1'b1, vecs[i].exp_r});
        end
        check("i2s_beat_count", 64'(qa.size()), 6);
        check("i2s_overflow_pulses", 64'(a_ovf_cnt), 0);
        check("i2s_frame_err_pulses", 64'(a_ferr_cnt), 0);

        // TDM, 8 slots carrying 1..8
        do_reset();
        tready = 1'b1;
        send_slot(1'b0, 1'b1, 24'h0);
        tdm_frame(8, 1);
        wait_beats(1'b1, 8);
        repeat (10) @(posedge aclk);
        check_tdm_frame("tdm_basic", 0, 1);
        check("tdm_basic_count", 64'(qb.size()), 8);
        check("tdm_basic_frame_err", 64'(b_ferr_cnt), 0);

        // I2S overflow with depth 4 and downstream stalled
        do_reset();
        tready = 1'b0;
        send_slot(1'b1, 1'b0, 24'h0);
        i2s_frame(24'h111111, 24'h222222);
        i2s_frame(24'h333333, 24'h444444);
        i2s_frame(24'h555555, 24'h666666);
        check("ovf_pulses", 64'(a_ovf_cnt), 1);
        check("ovf_frame_err", 64'(a_ferr_cnt), 0);
        tready = 1'b1;
        wait_beats(1'b0, 4);
        repeat (20) @(posedge aclk);
        check("ovf_beat_count", 64'(qa.size()), 4);
        check("ovf_beat0", 64'(beat(1'b0, 0) & 37'h1_FFFF_FFFF), {31'd0, 1'b0, 32'h11111100});
        check("ovf_beat1", 64'(beat(1'b0, 1) & 37'h1_FFFF_FFFF), {31'd0, 1'b1, 32'h22222200});
        check("ovf_beat2", 64'(beat(1'b0, 2) & 37'h1_FFFF_FFFF), {31'd0, 1'b0, 32'h33333300});
        check("ovf_beat3", 64'(beat(1'b0, 3) & 37'h1_FFFF_FFFF), {31'd0, 1'b1, 32'h44444400});

        // TDM short frame (5 of 8 slots) followed by a full frame
        do_reset();
        tready = 1'b1;
        send_slot(1'b0, 1'b1, 24'h0);
        tdm_frame(5, 24'h10);
        tdm_frame(8, 24'h20);
        wait_beats(1'b1, 8);
        repeat (10) @(posedge aclk);
        check("short_frame_err_pulses", 64'(b_ferr_cnt), 1);
        check("short_beat_count", 64'(qb.size()), 8);
        check_tdm_frame("short_next_frame", 0, 24'h20);

        // tready toggling every cycle across two TDM frames
        do_reset();
        tready = 1'b0;
        tog_en = 1'b1;
        fork
            while (tog_en) begin
                @(posedge aclk);
                #1 tready = ~tready;
            end
        join_none
        send_slot(1'b0, 1'b1, 24'h0);
        tdm_frame(8, 24'h31);
        tdm_frame(8, 24'h41);
        wait_beats(1'b1, 16);
        tog_en = 1'b0;
        repeat (3) @(posedge aclk);
        tready = 1'b1;
        repeat (10) @(posedge aclk);
        check("toggle_beat_count", 64'(qb.size()), 16);
        check_tdm_frame("toggle_frame0", 0, 24'h31);
        check_tdm_frame("toggle_frame1", 8, 24'h41);
        check("toggle_stalls_exercised", 64'(stall_seen > 0), 1);
        check("stall_hold_violations", 64'(stall_bad), 0);

        // Reset mid-slot with two committed beats pending
        do_reset();
        tready = 1'b0;
        send_slot(1'b1, 1'b0, 24'h0);
        i2s_frame(24'hABCDEF, 24'h13579B);
        repeat (5) @(posedge aclk);
        check("pending_tvalid", 64'(a_tvalid), 1);
        check("pending_tdata", 64'(a_tdata), 64'h00000000ABCDEF00);
        fork
            i2s_frame(24'h0BAD00, 24'h0BAD01);
            begin
                #803 rst = 1'b1;
                #1;
                check("async_rst_tvalid", 64'(a_tvalid), 0);
                check("async_rst_tdata", 64'(a_tdata), 0);
                #50 rst = 1'b0;
            end
        join
        tready = 1'b1;
        i2s_frame(24'h600DAA, 24'h600DBB);
        wait_beats(1'b0, 2);
        repeat (10) @(posedge aclk);
        check("post_rst_count", 64'(qa.size()), 2);
        check("post_rst_beat0", 64'(beat(1'b0, 0) & 37'h1_FFFF_FFFF), {31'd0, 1'b0, 32'h600DAA00});
        check("post_rst_beat1", 64'(beat(1'b0, 1) & 37'h1_FFFF_FFFF), {31'd0, 1'b1, 32'h600DBB00});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
